mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified instruction/data memory of the multi-cycle MIPS core between two requesters.
  - Port 0 (CPU): the control unit's fetch and lw/sw accesses.
  - Port 1 (DMA): a loader/debug DMA engine.
- Arbitrates between the two ports, holds one outstanding memory transaction at a time, and returns data with a done pulse.
- Aborts with an error if the memory does not respond within a bounded time.
- The control unit holds its current state while cpu_req is high and cpu_done has not yet pulsed.

Parameters:
ADDR_W, 32, address width of requesters and memory
DATA_W, 32, data width
TIMEOUT, 16, max cycles in BUSY without mem_ready before abort (>=2)
CPU_PRIO, 0, 0 = round-robin on contention; 1 = CPU always wins contention

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
cpu_req  input  1  CPU request, held until cpu_gnt
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_gnt  output  1  one-cycle pulse: CPU request accepted
cpu_done  output  1  one-cycle pulse: CPU transaction finished
cpu_err  output  1  valid with cpu_done: transaction timed out
dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  same as CPU fields, DMA port
dma_gnt, dma_done, dma_err  output  1 each  same as CPU fields, DMA port
rdata  output  DATA_W  read data, valid with either done pulse
mem_req  output  1  memory request, held until mem_ready or timeout
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid with mem_ready
mem_ready  input  1  memory completes the current access this cycle
busy  output  1  high in BUSY or DONE state

Behaviour:
- States: IDLE, BUSY, DONE. Registers: owner (0 = CPU, 1 = DMA), last_owner, latched we/addr/wdata, timeout counter, rdata, err.
- Reset values (immediate on reset):
  - state = IDLE; last_owner = 1, so the CPU wins the first tie.
  - All gnt/done/err outputs = 0; mem_req = 0; mem_we = 0; mem_addr, mem_wdata, rdata = 0; busy = 0; counter = 0.
- IDLE:
  - No requests: stay in IDLE.
  - Exactly one request: that port wins.
  - Both requesting:
    - CPU_PRIO = 1: CPU wins.
    - CPU_PRIO = 0: the port that is not last_owner wins.
  - On a win:
    - Latch the winner's we/addr/wdata.
    - Set owner; assert the winner's gnt for exactly one cycle (registered, visible in the first BUSY cycle).
    - Clear the counter; go to BUSY.
- BUSY:
  - mem_req = 1; mem_we/addr/wdata driven from latched values and held stable for the whole state.
  - The requester's inputs are ignored; they may change or drop after gnt.
  - mem_ready = 1:
    - Capture mem_rdata into rdata (read or write; content is don't-care for writes); err = 0.
    - Go to DONE.
  - Else if counter == TIMEOUT-1: err = 1, rdata unchanged, go to DONE.
  - Else: counter increments.
  - mem_ready has priority over timeout in the same cycle.
- DONE:
  - mem_req = 0.
  - owner's done pulses for exactly one cycle; owner's err = err; the other port's done/err = 0.
  - last_owner = owner; go to IDLE.
- Latency with a single requester and zero-wait memory:
  - req seen at edge N.
  - gnt and mem_req high in cycle N+1; mem_ready high in N+1.
  - done in N+2; IDLE in N+3.
  - Minimum 3 cycles per transaction; no overlap between transactions.
- A request still high in IDLE after a done is treated as a new request.
- mem_ready outside BUSY is ignored.
- Reset mid-transaction aborts silently: no done pulse; mem_req drops asynchronously.
- busy = 1 in BUSY and DONE.

Test Plan:
- CPU read only: cpu_req=1, we=0, addr=0x40; mem_ready pulsed the cycle after mem_req rises with mem_rdata=0x8C220004 -> cpu_gnt one pulse, mem_addr=0x40, mem_we=0; cpu_done pulse with rdata=0x8C220004, cpu_err=0; dma outputs stay 0.
- Contention, CPU_PRIO=0, both req held continuously for 4 transactions -> grants alternate CPU, DMA, CPU, DMA; each done goes to the matching port.
- Contention, CPU_PRIO=1, both req held -> CPU granted every transaction; DMA never granted until cpu_req drops.
- Write with wait states: dma_req, we=1, addr=0x100, wdata=0xDEADBEEF; dma inputs change to garbage after gnt; mem_ready after 5 BUSY cycles -> mem_addr/mem_wdata/mem_we stable at 0x100/0xDEADBEEF/1 throughout; dma_done 1 cycle after ready, dma_err=0.
- Timeout, TIMEOUT=16: mem_ready never asserted -> mem_req high exactly 16 cycles, then the owner's done pulses with err=1, then IDLE. Second run asserts mem_ready in BUSY cycle 16 -> err=0 (ready wins).
- Reset asserted in BUSY cycle 3 -> mem_req, busy low immediately; no done pulse; after release, a CPU/DMA tie is granted to the CPU.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, DMA port and memory-side signals of mem_port_arbiter.
// slave = arbiter view, master = requester/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_done;
    logic              cpu_err;

    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_done;
    logic              dma_err;

    logic [DATA_W-1:0] rdata;
    logic              busy;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata, mem_ready,
        output cpu_gnt, cpu_done, cpu_err,
        output dma_gnt, dma_done, dma_err,
        output rdata, busy,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata, mem_ready,
        input  cpu_gnt, cpu_done, cpu_err,
        input  dma_gnt, dma_done, dma_err,
        input  rdata, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port (CPU/DMA) arbiter for the single shared memory; one outstanding access,
// minimum 3 cycles per transaction (IDLE->BUSY->DONE), timeout-abort after TIMEOUT BUSY cycles.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int TIMEOUT  = 16,
    parameter int CPU_PRIO = 0
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner;
    logic              last_owner;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rdata_q;
    logic              err;
    logic              cpu_gnt_q;
    logic              dma_gnt_q;

    logic              start;
    logic              winner;
    logic              ready_hit;
    logic              expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        winner    = 1'b0;
        ready_hit = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    start     = 1'b1;
                    state_nxt = BUSY;
                    // On a tie the port that did not own the last transaction wins, unless CPU has priority.
                    if (bus.cpu_req && bus.dma_req)
                        winner = (CPU_PRIO != 0) ? 1'b0 : ~last_owner;
                    else
                        winner = ~bus.cpu_req;
                end
            end
            BUSY: begin
                if (bus.mem_ready) begin
                    ready_hit = 1'b1;
                    state_nxt = DONE;
                end else if (cnt == CNT_LAST) begin
                    expire    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            rdata_q    <= '0;
            err        <= 1'b0;
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
        end else begin
            cpu_gnt_q <= start & ~winner;
            dma_gnt_q <= start &  winner;
            if (start) begin
                owner     <= winner;
                lat_we    <= winner ? bus.dma_we    : bus.cpu_we;
                lat_addr  <= winner ? bus.dma_addr  : bus.cpu_addr;
                lat_wdata <= winner ? bus.dma_wdata : bus.cpu_wdata;
                cnt       <= '0;
            end else if (state == BUSY && !ready_hit && !expire) begin
                cnt <= cnt + 1'b1;
            end
            if (ready_hit) begin
                rdata_q <= bus.mem_rdata;
                err     <= 1'b0;
            end else if (expire) begin
                err <= 1'b1;
            end
            if (state == DONE) last_owner <= owner;
        end
    end

    // Memory-side controls derive from state so reset drops mem_req without waiting for a clock.
    assign bus.mem_req   = (state == BUSY);
    assign bus.mem_we    = (state == BUSY) & lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    assign bus.cpu_gnt   = cpu_gnt_q;
    assign bus.dma_gnt   = dma_gnt_q;
    assign bus.cpu_done  = (state == DONE) & ~owner;
    assign bus.dma_done  = (state == DONE) &  owner;
    assign bus.cpu_err   = (state == DONE) & ~owner & err;
    assign bus.dma_err   = (state == DONE) &  owner & err;

    assign bus.rdata     = rdata_q;
    assign bus.busy      = (state == BUSY) || (state == DONE);
endmodule
